// File: rtl/lstm_seq_ctrl.sv
// lstm_seq_ctrl: steps the LSTM datapath through a job of num_steps timesteps.
// Each timestep runs three handshaked phases: LOAD, GATE and UPD. A per-phase
// watchdog and a level abort can end a job early. At job end, irq pulses for
// one cycle.
// Optional macro LSTM_SEQ_PERF_CNT_EN adds a 16-bit busy-cycle counter. The
// counter is shown on status_word[31:16].
module lstm_seq_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int STEP_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic [DATA_WIDTH-1:0] ctrl_word,
  output logic [DATA_WIDTH-1:0] status_word,
  output logic                  load_req,
  input  logic                  load_ack,
  output logic                  gate_start,
  input  logic                  gate_done,
  output logic                  upd_start,
  input  logic                  upd_done,
  output logic [STEP_WIDTH-1:0] step_idx,
  output logic                  irq
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_LOAD       = 3'd1;
  localparam logic [2:0] S_GATE_ISSUE = 3'd2;
  localparam logic [2:0] S_GATE_WAIT  = 3'd3;
  localparam logic [2:0] S_UPD_ISSUE  = 3'd4;
  localparam logic [2:0] S_UPD_WAIT   = 3'd5;
  localparam logic [2:0] S_FINISH     = 3'd6;

  // The watchdog only has to reach TIMEOUT_CYCLES-1. A limit of 0 disables it.
  localparam int              WD_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]            state_reg, state_next;
  logic                  start_prev_reg;
  logic [STEP_WIDTH-1:0] num_steps_reg, num_steps_next;
  logic [STEP_WIDTH-1:0] step_idx_reg, step_idx_next;
  logic [WD_W-1:0]       wd_reg, wd_next;
  logic                  done_reg, done_next;
  logic                  err_reg, err_next;
  logic                  aborted_reg, aborted_next;
  logic                  irq_int;

  logic                  start_edge, abort_req, accept_start;
  logic                  waiting, awaited_ack, wd_expire, last_step;
  logic [STEP_WIDTH-1:0] num_in;
  logic [7:0]            step8;
  logic [15:0]           perf_field;
  logic                  unused_ctrl;

  assign start_edge   = ctrl_word[0] & ~start_prev_reg;
  assign abort_req    = ctrl_word[1];
  assign accept_start = (state_reg == S_IDLE) & start_edge & ~abort_req;
  assign num_in       = STEP_WIDTH'(ctrl_word[15:8]);
  assign last_step    = (step_idx_reg == num_steps_reg - STEP_WIDTH'(1));
  assign unused_ctrl  = ^{ctrl_word[DATA_WIDTH-1:16], ctrl_word[7:2]};

  // Select the handshake that the current wait state is waiting for.
  always_comb begin
    waiting     = 1'b0;
    awaited_ack = 1'b0;
    case (state_reg)
      S_LOAD:      begin waiting = 1'b1; awaited_ack = load_ack;  end
      S_GATE_WAIT: begin waiting = 1'b1; awaited_ack = gate_done; end
      S_UPD_WAIT:  begin waiting = 1'b1; awaited_ack = upd_done;  end
      default:     begin waiting = 1'b0; awaited_ack = 1'b0;      end
    endcase
  end

  assign wd_expire = (TIMEOUT_CYCLES != 0) && waiting && !awaited_ack && (wd_reg == WD_LIMIT);

  // Next-state logic. Abort has priority over timeout, and timeout has priority over normal progress.
  always_comb begin
    state_next     = state_reg;
    num_steps_next = num_steps_reg;
    step_idx_next  = step_idx_reg;
    wd_next        = wd_reg;
    done_next      = done_reg;
    err_next       = err_reg;
    aborted_next   = aborted_reg;
    irq_int        = 1'b0;
    if (state_reg != S_IDLE && abort_req) begin
      state_next   = S_IDLE;
      aborted_next = 1'b1;
      irq_int      = 1'b1;
    end else if (wd_expire) begin
      state_next = S_IDLE;
      err_next   = 1'b1;
      irq_int    = 1'b1;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (accept_start) begin
            num_steps_next = num_in;
            step_idx_next  = '0;
            done_next      = 1'b0;
            err_next       = 1'b0;
            aborted_next   = 1'b0;
            wd_next        = '0;
            state_next     = (num_in == '0) ? S_FINISH : S_LOAD;
          end
        end
        S_LOAD: begin
          if (load_ack) state_next = S_GATE_ISSUE;
          else          wd_next    = wd_reg + WD_W'(1);
        end
        S_GATE_ISSUE: begin
          state_next = S_GATE_WAIT;
          wd_next    = '0;
        end
        S_GATE_WAIT: begin
          if (gate_done) state_next = S_UPD_ISSUE;
          else           wd_next    = wd_reg + WD_W'(1);
        end
        S_UPD_ISSUE: begin
          state_next = S_UPD_WAIT;
          wd_next    = '0;
        end
        S_UPD_WAIT: begin
          if (upd_done) begin
            if (last_step) begin
              state_next = S_FINISH;
            end else begin
              step_idx_next = step_idx_reg + STEP_WIDTH'(1);
              wd_next       = '0;
              state_next    = S_LOAD;
            end
          end else begin
            wd_next = wd_reg + WD_W'(1);
          end
        end
        S_FINISH: begin
          done_next  = 1'b1;
          irq_int    = 1'b1;
          state_next = S_IDLE;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Sequencer registers. start_prev resets high, so a start bit held through reset is not taken as an edge.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_reg      <= S_IDLE;
      start_prev_reg <= 1'b1;
      num_steps_reg  <= '0;
      step_idx_reg   <= '0;
      wd_reg         <= '0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
      aborted_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      start_prev_reg <= ctrl_word[0];
      num_steps_reg  <= num_steps_next;
      step_idx_reg   <= step_idx_next;
      wd_reg         <= wd_next;
      done_reg       <= done_next;
      err_reg        <= err_next;
      aborted_reg    <= aborted_next;
    end
  end

`ifdef LSTM_SEQ_PERF_CNT_EN
  logic [15:0] perf_reg;

  // Count busy cycles of the current job. The count saturates, and it holds while idle.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET)                                          perf_reg <= '0;
    else if (accept_start)                               perf_reg <= '0;
    else if (state_reg != S_IDLE && perf_reg != 16'hFFFF) perf_reg <= perf_reg + 16'd1;
  end

  assign perf_field = perf_reg;
`else
  assign perf_field = 16'h0000;
`endif

  assign load_req   = (state_reg == S_LOAD);
  assign gate_start = (state_reg == S_GATE_ISSUE);
  assign upd_start  = (state_reg == S_UPD_ISSUE);
  assign step_idx   = step_idx_reg;
  assign irq        = irq_int;
  assign step8      = 8'(step_idx_reg);

  // Pack the read-only status register. Unused bits are zero.
  always_comb begin
    status_word        = '0;
    status_word[0]     = (state_reg != S_IDLE);
    status_word[1]     = done_reg;
    status_word[2]     = err_reg;
    status_word[3]     = aborted_reg;
    status_word[15:8]  = step8;
    status_word[31:16] = perf_field;
  end

endmodule
